uart_tx_serializer: RTL and testbench

- DUT-side UART transmitter: accepts bytes on a valid/ready handshake and serializes them onto `txd`.
- Frame format is 8N1 by default, LSB first, with programmable baud divisor.
- Sits between the bridge's response path and the physical `txd` pin.
- Pairs with the testbench UART agent, which samples `txd` through the monitor/driver modports.

---
 rtl/uart_tx_serializer.sv | 115 +++++++++++
 tb/tb_uart_tx_serializer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// 8N1/8N2 UART transmitter with valid/ready byte input and programmable baud divisor.
// Optional parity bit (8E1/8O1) when UART_TX_PARITY_EN is defined.
module uart_tx_serializer #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       txd,
    output logic       busy
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          bit_end;
    logic          accept;
`ifdef UART_TX_PARITY_EN
    logic          par_bit;
`endif

    assign bit_end = (baud_cnt == BAUD_LAST);
    assign accept  = tx_valid && (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (tx_valid) state_nxt = START;
            START: if (bit_end) state_nxt = DATA;
`ifdef UART_TX_PARITY_EN
            DATA:   if (bit_end && bit_cnt == 3'd7) state_nxt = PARITY;
            PARITY: if (bit_end) state_nxt = STOP;
`else
            DATA:  if (bit_end && bit_cnt == 3'd7) state_nxt = STOP;
`endif
            STOP:  if (bit_end && bit_cnt == STOP_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Baud/bit counters and shift register; bit_cnt also counts stop bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
`ifdef UART_TX_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else if (accept) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= tx_data;
`ifdef UART_TX_PARITY_EN
            par_bit  <= (^tx_data) ^ 1'(PARITY_ODD);
`endif
        end else if (state != IDLE) begin
            baud_cnt <= bit_end ? '0 : baud_cnt + CW'(1);
            if (bit_end && state == DATA) begin
                bit_cnt <= bit_cnt + 3'd1;
                shreg   <= {1'b0, shreg[7:1]};
            end
            if (bit_end && state == STOP) begin
                bit_cnt <= (bit_cnt == STOP_LAST) ? 3'd0 : bit_cnt + 3'd1;
            end
        end
    end

    always_comb begin
        txd      = 1'b1;
        busy     = (state != IDLE);
        tx_ready = (state == IDLE);
        case (state)
            START:   txd = 1'b0;
            DATA:    txd = shreg[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  txd = par_bit;
`endif
            default: txd = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (CLKS_PER_BIT >= 2 && (STOP_BITS == 1 || STOP_BITS == 2) && PARITY_ODD <= 1);
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: two lanes (1 and 2 stop bits, CPB=4) checked every cycle
// against a frame-waveform model; honours UART_TX_PARITY_EN.
module tb_uart_tx_serializer;

    localparam int unsigned CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data [2] = '{8'h00, 8'h00};
    logic       tx_valid [2] = '{1'b0, 1'b0};
    logic       tx_ready0, txd0, busy0;
    logic       tx_ready1, txd1, busy1;
    logic       rdy_w [2];
    logic       txd_w [2];
    logic       busy_w [2];

    int n_cmp = 0;
    int n_bad = 0;
    logic started = 1'b0;

    always #5 clk = ~clk;

    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(0)) dut0 (
        .clk(clk), .rst(rst), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready0), .txd(txd0), .busy(busy0)
    );
    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_ODD(1)) dut1 (
        .clk(clk), .rst(rst), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready1), .txd(txd1), .busy(busy1)
    );

    assign rdy_w[0]  = tx_ready0;
    assign rdy_w[1]  = tx_ready1;
    assign txd_w[0]  = txd0;
    assign txd_w[1]  = txd1;
    assign busy_w[0] = busy0;
    assign busy_w[1] = busy1;

    // Frame as a bit list: start, 8 data LSB first, optional parity, then stop bits (all 1s).
    function automatic logic [11:0] build(input int k, input logic [7:0] d);
        logic [11:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
`ifdef UART_TX_PARITY_EN
        f[9]   = (^d) ^ (k == 1);
`endif
        return f;
    endfunction

    function automatic int flen(input int k);
        return 9 + PB + ((k == 0) ? 1 : 2);
    endfunction

    // Model: a frame occupies flen*CPB cycles after its accept edge; ready only when no frame.
    int          cyc = 0;
    logic        m_active [2] = '{1'b0, 1'b0};
    int          m_age    [2] = '{0, 0};
    logic [11:0] m_frame  [2] = '{12'hfff, 12'hfff};
    logic [7:0]  m_last   [2] = '{8'h00, 8'h00};
    int          acc_cnt  [2] = '{0, 0};
    int          acc_cyc  [2] = '{0, 0};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_active[k] <= 1'b0;
            end else if (!m_active[k]) begin
                if (tx_valid[k]) begin
                    m_active[k] <= 1'b1;
                    m_age[k]    <= 1;
                    m_frame[k]  <= build(k, tx_data[k]);
                    m_last[k]   <= tx_data[k];
                    acc_cnt[k]  <= acc_cnt[k] + 1;
                    acc_cyc[k]  <= cyc + 1;
                end
            end else begin
                m_age[k] <= m_age[k] + 1;
                if (m_age[k] >= flen(k) * int'(CPB)) m_active[k] <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                logic et;
                et = m_active[k] ? m_frame[k][(m_age[k] - 1) / int'(CPB)] : 1'b1;
                check($sformatf("lane%0d txd", k), 32'(txd_w[k]), 32'(et));
                check($sformatf("lane%0d busy", k), 32'(busy_w[k]), 32'(m_active[k]));
                check($sformatf("lane%0d tx_ready", k), 32'(rdy_w[k]), 32'(!m_active[k]));
            end
        end
    end

    task automatic send_change(input int k, input logic [7:0] d1, input logic [7:0] d2, input int w);
        int n0;
        int t;
        n0 = acc_cnt[k];
        t  = 0;
        tx_data[k]  = d1;
        tx_valid[k] = 1'b1;
        while (acc_cnt[k] == n0 && t < w) begin
            @(negedge clk);
            t++;
        end
        if (acc_cnt[k] == n0) tx_data[k] = d2;
        t = 0;
        while (acc_cnt[k] == n0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (acc_cnt[k] == n0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL lane%0d accept timeout: got no accept required one", k);
        end
        tx_valid[k] = 1'b0;
    endtask

    task automatic send(input int k, input logic [7:0] d);
        send_change(k, d, d, 0);
    endtask

    task automatic wait_idle(input int k);
        int t;
        t = 0;
        while (m_active[k] && t < 200) begin
            @(negedge clk);
            t++;
        end
    endtask

    // Hand-computed bit pattern sampled mid-bit plus accept-to-ready latency.
    task automatic frame_literal(input int k, input logic [7:0] d, input logic [11:0] pat,
                                 input int nbits, input int delay);
        int t;
        send(k, d);
        repeat (2) @(negedge clk);
        for (int j = 0; j < nbits; j++) begin
            check($sformatf("lane%0d byte %02h bit%0d", k, d, j), 32'(txd_w[k]), 32'(pat[j]));
            if (j < nbits - 1) repeat (CPB) @(negedge clk);
        end
        t = 0;
        while (!rdy_w[k] && t < 100) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("lane%0d byte %02h ready latency", k, d), 32'(cyc - acc_cyc[k]), 32'(delay));
    endtask

    task automatic lane_rand(input int k);
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if ($urandom_range(0, 2) == 0)
                send_change(k, 8'($urandom), 8'($urandom), int'($urandom_range(1, 30)));
            else
                send(k, 8'($urandom));
        end
        wait_idle(k);
    endtask

    initial begin
        int a1;
        repeat (2) @(negedge clk);
        started = 1'b1;
        check("reset txd0", 32'(txd0), 32'd1);
        check("reset busy0", 32'(busy0), 32'd0);
        check("reset ready0", 32'(tx_ready0), 32'd1);
        check("reset ready1", 32'(tx_ready1), 32'd1);
        rst = 1'b0;
        @(negedge clk);

`ifdef UART_TX_PARITY_EN
        frame_literal(0, 8'h55, 12'b111_0010101010 & 12'h7ff, 11, 44);
        frame_literal(1, 8'h80, 12'b110100000000, 12, 48);
        frame_literal(0, 8'h07, 12'b0000_11000001110 & 12'h7ff, 11, 44);
        frame_literal(1, 8'h07, 12'b110000001110, 12, 48);
`else
        frame_literal(0, 8'h55, 12'b00_1010101010, 10, 40);
        frame_literal(1, 8'h80, 12'b0_11100000000 | 12'b0, 11, 44);
`endif
        @(negedge clk);

        // Back-to-back with tx_valid held: one idle clock between frames.
        send(0, 8'hA3);
        a1 = acc_cyc[0];
        send(0, 8'h0F);
        check("b2b accept spacing", 32'(acc_cyc[0] - a1), 32'(4 * (10 + PB) + 1));
        check("b2b second byte", 32'(m_last[0]), 32'h0F);
        wait_idle(0);

        // Reset during data bit 3 of 0xFF, then a clean 0x00.
        send(0, 8'hFF);
        repeat (18) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort txd0", 32'(txd0), 32'd1);
        check("abort ready0", 32'(tx_ready0), 32'd1);
        check("abort busy0", 32'(busy0), 32'd0);
        send(0, 8'h00);
        wait_idle(0);

        // Held-off byte changes before ready: only the final value is latched.
        send(0, 8'hAA);
        send_change(0, 8'h12, 8'h34, 5);
        check("held-off byte", 32'(m_last[0]), 32'h34);
        wait_idle(0);

        fork
            lane_rand(0);
            lane_rand(1);
        join
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
